// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_pkg
//  Brief    : Unit indices, default latencies and unit-index width helper
//  Revision : 1.0
// ============================================================================
package mdu_pkg;

   localparam int UNIT_MUL      = 0;
   localparam int UNIT_DIV      = 1;
   localparam int DEF_FIXED_LAT = 4;
   localparam int DEF_MAX_LAT   = 40;

   // A single unit still needs a one-bit index.
   function automatic int unit_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_age_counter.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_age_counter
//  Brief    : Saturating age of the outstanding op with latency/watchdog taps
//  Revision : 1.0
// ============================================================================
module mdu_age_counter #(
   parameter int FIXED_LAT = 4,
   parameter int MAX_LAT   = 40
) (
   input  logic clk,
   input  logic resetn,
   input  logic clear,
   input  logic enable,
   output logic at_fixed,
   output logic at_max
);

   localparam int AW = $clog2(MAX_LAT + 1);

   logic [AW-1:0] age_q;
   logic [AW-1:0] age_d;

   always_comb begin
      age_d = age_q;
      if (clear) begin
         age_d = '0;
      end else if (enable && (age_q != AW'(MAX_LAT))) begin
         age_d = age_q + AW'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         age_q <= '0;
      end else begin
         age_q <= age_d;
      end
   end

   assign at_fixed = (age_q == AW'(FIXED_LAT - 1));
   assign at_max   = (age_q == AW'(MAX_LAT));

endmodule
`default_nettype wire

// File: rtl/mdu_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : mdu_scoreboard
//  Brief    : Tracks the single outstanding HI/LO-producing op, stalls decode
//  Revision : 1.0
// ============================================================================
module mdu_scoreboard
   import mdu_pkg::*;
#(
   parameter int                        NUM_UNITS  = 2,
   parameter logic [NUM_UNITS-1:0]      FIXED_MASK = 2'b01,
   parameter int                        FIXED_LAT  = DEF_FIXED_LAT,
   parameter int                        MAX_LAT    = DEF_MAX_LAT
) (
   input  logic                         clk,
   input  logic                         resetn,
   input  logic                         issue_valid,
   input  logic [unit_w(NUM_UNITS)-1:0] issue_unit,
   input  logic                         hilo_access,
   input  logic [NUM_UNITS-1:0]         complete,
   input  logic                         flush,
   output logic                         stall,
   output logic                         issue_accept,
   output logic [NUM_UNITS-1:0]         busy,
   output logic                         hilo_we,
   output logic [unit_w(NUM_UNITS)-1:0] hilo_sel,
   output logic [NUM_UNITS-1:0]         abort,
   output logic                         timeout_err
);

   localparam int UW = unit_w(NUM_UNITS);

   logic [NUM_UNITS-1:0] busy_q,    busy_d;
   logic [UW-1:0]        sel_q,     sel_d;
   logic                 timeout_q, timeout_d;

   logic any_busy;
   logic cur_fixed;
   logic done_now;
   logic watchdog;
   logic kill;
   logic unit_ok;
   logic at_fixed;
   logic at_max;

   // While busy, sel_q always names the busy unit, so it doubles as its index.
   assign any_busy  = |busy_q;
   assign cur_fixed = FIXED_MASK[sel_q];
   assign done_now  = any_busy & (cur_fixed ? at_fixed : complete[sel_q]);
   assign watchdog  = any_busy & ~cur_fixed & at_max & ~complete[sel_q];
   assign kill      = any_busy & ~done_now & (flush | watchdog);
   assign unit_ok   = (32'(issue_unit) < NUM_UNITS);

   assign stall        = ~flush & ((hilo_access & any_busy) |
                                   (issue_valid & any_busy & ~done_now));
   assign issue_accept = issue_valid & ~flush & ~stall & unit_ok;
   assign hilo_we      = done_now;
   assign abort        = busy_q & {NUM_UNITS{kill}};

   always_comb begin
      busy_d    = busy_q;
      sel_d     = sel_q;
      timeout_d = timeout_q | watchdog;
      if (issue_accept) begin
         busy_d = NUM_UNITS'(1) << issue_unit;
         sel_d  = issue_unit;
      end else if (done_now || kill) begin
         busy_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q    <= '0;
         sel_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         busy_q    <= busy_d;
         sel_q     <= sel_d;
         timeout_q <= timeout_d;
      end
   end

   mdu_age_counter #(
      .FIXED_LAT (FIXED_LAT),
      .MAX_LAT   (MAX_LAT)
   ) u_age (
      .clk      (clk),
      .resetn   (resetn),
      .clear    (issue_accept),
      .enable   (any_busy & ~done_now),
      .at_fixed (at_fixed),
      .at_max   (at_max)
   );

   assign busy        = busy_q;
   assign hilo_sel    = sel_q;
   assign timeout_err = timeout_q;

endmodule
`default_nettype wire

// File: doc/mdu_scoreboard.md
# mdu_scoreboard

Parametrised tracker for long-latency HI/LO-producing operations (multiply, divide, and future units), replacing the single-divider `div_valid` flag in decode. Sits in the decode stage. It accepts issues of multi-cycle ops, tracks the one outstanding op per HI/LO, and times completion either by a unit handshake or a fixed latency. It generates the decode stall for HI/LO accesses and back-to-back issues, aborts in-flight work on pipeline flush, and flags hung units.

## Interface
- `NUM_UNITS`, 2: number of long-latency units; unit index width `UW = max(1, $clog2(NUM_UNITS))`.
- `FIXED_MASK`, 2'b01: bit u=1 means unit u finishes after exactly `FIXED_LAT` cycles; bit u=0 means unit u signals `complete[u]`.
- `FIXED_LAT`, 4: latency of fixed units in cycles; legal range 1..`MAX_LAT`.
- `MAX_LAT`, 40: watchdog limit for handshake units; the age counter width is `$clog2(MAX_LAT+1)`.
- `clk` in 1: clock. All state changes on its rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: decode holds a mult/div-class op.
- `issue_unit` in UW: target unit of that op.
- `hilo_access` in 1: decode holds mfhi/mflo/mthi/mtlo.
- `complete` in NUM_UNITS: per-unit result-ready pulse (handshake units only).
- `flush` in 1: pipeline flush (exception/eret).
- `stall` out 1: combinational; freeze decode this cycle.
- `issue_accept` out 1: combinational; the op is launched this cycle.
- `busy` out NUM_UNITS: registered; at most one bit set.
- `hilo_we` out 1: combinational; HI/LO capture the result at this edge.
- `hilo_sel` out UW: registered; unit owning the pending or last result.
- `abort` out NUM_UNITS: combinational one-cycle kill to unit datapaths.
- `timeout_err` out 1: registered, sticky.

## Operation
- Reset values: `busy`=0, `hilo_sel`=0, age=0, `timeout_err`=0. With `busy`=0, all combinational outputs are 0.
- `done_now` = the busy unit is finishing this cycle:
  - handshake unit: `complete[u]`.
  - fixed unit: age == `FIXED_LAT`-1.
- `hilo_we` = `done_now`.
- `stall` = ~`flush` & ( (`hilo_access` & |`busy`) | (`issue_valid` & |`busy` & ~`done_now`) ).
  - `hilo_access` stalls in the completion cycle too. The read proceeds the following cycle from the updated HI/LO.
- `issue_accept` = `issue_valid` & ~`flush` & ~`stall`. On acceptance:
  - `busy` <= onehot(`issue_unit`)
  - `hilo_sel` <= `issue_unit`
  - age <= 0
- Issue in the same cycle as `done_now`: the old op retires (`hilo_we`=1) and the new op is accepted; `busy` switches at that edge.
- While busy and not done: age increments by 1 and saturates at `MAX_LAT`.
- `done_now` without a new issue: `busy` <= 0.
- Flush while busy and not `done_now`:
  - `abort[u]` = 1 for the busy unit.
  - `busy` <= 0.
  - No `hilo_we`.
  - Any issue that cycle is rejected.
- Flush coinciding with `done_now`: the completion wins (`hilo_we`=1, no abort) and `busy` clears.
- Watchdog: a handshake unit with age == `MAX_LAT` and no `complete` asserts `abort`, clears `busy`, and sets `timeout_err`. Only reset clears `timeout_err`.
- Ignored inputs:
  - `complete[u]` for a unit that is not busy, or for a fixed unit.
  - `issue_unit` >= `NUM_UNITS`: not accepted; `stall` is unaffected.
- Asynchronous reset mid-operation discards the op; no `abort` pulse is generated.

## Timing
- Issue at cycle t → `busy` set from t+1.
- Fixed unit: `hilo_we` in cycle t+`FIXED_LAT`, `busy` clear from t+`FIXED_LAT`+1.
- Handshake unit: `hilo_we` in the same cycle as `complete`. Earliest useful `complete` is t+1.
- Stall to release: zero added cycles beyond the completion cycle for issue; one cycle for a HI/LO access.
- Flush effect is visible on `busy` at the next edge.

## Structure
- Package `mdu_pkg`: `UNIT_MUL`=0, `UNIT_DIV`=1, default `FIXED_LAT`/`MAX_LAT`, and the unit-index width function.
- One natural sub-module: `mdu_age_counter` (clear, enable, saturating count, compare outputs for `FIXED_LAT`-1 and `MAX_LAT`).

## Test plan
- Fixed mult: issue unit 0 at cycle 10; `mfhi` held from cycle 11 → `stall`=1 for cycles 11–14, `hilo_we` at 14, `hilo_access` released at 15, `busy`=0 at 15.
- Divider: issue unit 1 at cycle 5, `complete[1]` at 38, second div issued at 20 → stalled 20–37, accepted at 38 with `hilo_we`=1, `busy`=2'b10 continuously.
- Flush: div in flight (age 7), `flush`=1 → `abort`=2'b10 for one cycle, `busy`=0 next cycle, no `hilo_we`. Repeat with `flush` and `complete[1]` in the same cycle → `hilo_we`=1, `abort`=0.
- Watchdog: div issued, no `complete` → at age 40 `abort`=2'b10, `timeout_err`=1 and stays 1; a later `complete[1]` is ignored.
- Reset: assert `resetn`=0 mid-divide between clock edges → `busy`, `hilo_sel`, `timeout_err` go 0 immediately. A spurious `complete`=2'b11 when idle → no `hilo_we`.
- Parameter sweep with `NUM_UNITS`=4, `FIXED_MASK`=4'b0101, `FIXED_LAT`=1: issue unit 2 → `hilo_we` in cycle t+1; unit 3 behaves as a handshake unit.
